updown_counter_seg: RTL and testbench
=====================================

Name: updown_counter_seg

Overview:
Parametrised synchronous up/down counter with programmable modulus, wrap or saturate mode, parallel load and a terminal-count pulse. Includes a time-multiplexed 7-segment driver that shows the count in hex across NDIGITS digits, with a direction indicator on the decimal point. It sits between the board switches/buttons (en, up, load) and the on-board 7-segment display. It replaces the fixed 4-bit lab counter.

Parameters:
WIDTH, 4, counter width in bits (1..16)
MOD, 16, modulus; count range 0..MOD-1; legal range 2 <= MOD <= 2**WIDTH
SATURATE, 0, 0 = wrap at limits; 1 = hold at limits
NDIGITS, 1, number of 7-seg digits scanned (1..4)
SCAN_DIV, 1000, clk cycles each digit stays selected (>=1)
SEG_ACTIVE_LOW, 1, 1 = seg, dp and an are driven active-low

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
en  in  1  count enable
up  in  1  direction: 1 = increment, 0 = decrement
load  in  1  synchronous parallel load strobe
load_val  in  WIDTH  value to load
count  out  WIDTH  current count, registered
tc  out  1  one-cycle terminal-count pulse, registered
dir  out  1  registered copy of up, sampled whenever en or load is 1
seg  out  7  segments a..g on seg[0]..seg[6]
dp  out  1  decimal point
an  out  NDIGITS  one-hot digit select

Behaviour:
- Reset is synchronous, active-low, on `reset` (clock `clk`). With reset=0 at a rising edge:
  - count=0, tc=0, dir=1.
  - Scan prescaler=0, digit index=0.
  - an selects digit 0; seg shows "0"; dp is off.
  - Reset overrides load and en.
- Priority each cycle: reset > load > en > hold.
- Load:
  - count <= min(load_val, MOD-1). A value >= MOD is clamped to MOD-1.
  - tc=0 on the cycle after a load.
  - dir <= up.
- Count (en=1, load=0):
  - up=1, count<MOD-1: count+1.
  - up=1, count=MOD-1: wrap to 0, or hold if SATURATE=1.
  - up=0, count>0: count-1.
  - up=0, count=0: wrap to MOD-1, or hold if SATURATE=1.
- tc is asserted for exactly one cycle after an enabled step taken at a limit: up at MOD-1, or down at 0. This applies in both modes. In saturate mode tc repeats every enabled cycle while held at the limit.
- en=0 and load=0: count, dir hold; tc=0.
- Latency: count and tc change one clock after the sampling edge.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. At terminal it advances the digit index 0..NDIGITS-1 and wraps.
  - an is one-hot on the digit index.
  - Digit i displays hex nibble i of count. Nibbles above WIDTH are zero-filled.
  - seg/an/dp are registered: one cycle after the index or count changes.
- dp is lit only on digit 0, and only when dir=0 (counting down).
- If SEG_ACTIVE_LOW=1, seg/dp/an are inverted at the output registers.
- Segment encoding is the standard hex font 0-F:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
  - Values are active-high, bit0=a.
- NDIGITS=1 with SCAN_DIV irrelevant: an is held constant.
- Illegal MOD is rejected by an elaboration-time check.

Decomposition:
- Package updown_seg_pkg:
  - Hex font constant array, 16 x 7 bits.
  - Mode constants WRAP=0 and SAT=1.
  - Function clog2 for prescaler and index widths.
- One sub-module, hex_to_seg7: combinational 4-bit to 7-bit lookup with polarity parameter, instantiated once on the selected nibble.
- Counter, prescaler and digit scan live in the top module.

Test Plan:
- Reset/defaults (WIDTH=4, MOD=10, SAT=0, SEG_ACTIVE_LOW=1): hold reset=0 for 3 cycles -> count=0, tc=0, dir=1, an=0b0, seg=~0x3F=0x40, dp=1 (off).
- Wrap up: en=1, up=1 for 12 cycles from 0 -> count 1..9, 0, 1, 2; tc=1 only the cycle count returns to 0.
- Wrap down and dp: load_val=0, load=1, then en=1, up=0 -> count 9, 8, 7; tc pulses when entering 9; dp=0 (lit) on digit 0.
- Saturate/clamp (SAT=1): load_val=15 -> count=9 (clamped); en=1, up=1 for 3 cycles -> count stays 9, tc=1 every cycle; up=0 once -> 8, tc=0.
- Priority/reset mid-operation: load=1, en=1 together -> load wins. Then reset=0 while en=1 -> next edge count=0, tc=0, and counting resumes from 1 the cycle after reset=1.
- Scan (WIDTH=8, NDIGITS=2, SCAN_DIV=4): load 0xA3 -> an alternates every 4 cycles; digit 0 shows 3 (seg=~0x4F), digit 1 shows A (seg=~0x77).

Source files
------------

// File: rtl/updown_seg_pkg.sv
// Shared constants for the up/down counter and its 7-segment scan driver.
package updown_seg_pkg;

  // Counter limit behaviour selectors for the SATURATE parameter.
  localparam int WRAP = 0;
  localparam int SAT  = 1;

  // Hex font 0..F, active-high, bit0 = segment a ... bit6 = segment g.
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Ceiling log2; returns 0 for values <= 1, so callers clamp to at least 1 bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to 7-segment pattern, with selectable output polarity.
module hex_to_seg7
  import updown_seg_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Font lookup, inverted when the display segments are driven low.
  always_comb begin
    seg = HEX_FONT[nibble];
    if (ACTIVE_LOW != 0) seg = ~seg;
  end

endmodule

// File: rtl/updown_counter_seg.sv
// Up/down counter with programmable modulus, wrap or saturate at the limits,
// parallel load, terminal-count pulse and a multiplexed hex 7-segment driver.
module updown_counter_seg
  import updown_seg_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int MOD            = 16,
  parameter int SATURATE       = WRAP,
  parameter int NDIGITS        = 1,
  parameter int SCAN_DIV       = 1000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               up,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic               dir,
  output logic [6:0]         seg,
  output logic               dp,
  output logic [NDIGITS-1:0] an
);

  if ((MOD < 2) || (MOD > (1 << WIDTH))) begin : g_bad_mod
    $error("updown_counter_seg: MOD must satisfy 2 <= MOD <= 2**WIDTH");
  end
  if ((WIDTH < 1) || (WIDTH > 16)) begin : g_bad_width
    $error("updown_counter_seg: WIDTH must be 1..16");
  end
  if ((NDIGITS < 1) || (NDIGITS > 4)) begin : g_bad_ndigits
    $error("updown_counter_seg: NDIGITS must be 1..4");
  end
  if (SCAN_DIV < 1) begin : g_bad_scandiv
    $error("updown_counter_seg: SCAN_DIV must be >= 1");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);
  localparam int PW = (clog2(SCAN_DIV) < 1) ? 1 : clog2(SCAN_DIV);
  localparam int IW = (clog2(NDIGITS) < 1) ? 1 : clog2(NDIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] DIGIT_LAST = IW'(NDIGITS - 1);
  localparam logic [6:0] SEG_RST = (SEG_ACTIVE_LOW != 0) ? ~HEX_FONT[0] : HEX_FONT[0];
  localparam logic [NDIGITS-1:0] AN_ONE = NDIGITS'(1);
  localparam logic [NDIGITS-1:0] AN_RST = (SEG_ACTIVE_LOW != 0) ? ~AN_ONE : AN_ONE;
  localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0);

  // Loaded values outside 0..MOD-1 are pinned to the top of the range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // One enabled step; at a limit either wrap to the other end or hold there.
  function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] c,
                                                  input logic u,
                                                  input logic lim);
    logic [WIDTH-1:0] r;
    if (lim) begin
      if (SATURATE == SAT) r = c;
      else r = u ? '0 : MAXV;
    end else begin
      r = u ? (c + WIDTH'(1)) : (c - WIDTH'(1));
    end
    return r;
  endfunction

  logic          at_limit;
  logic [PW-1:0] presc;
  logic [IW-1:0] digit;

  assign at_limit = up ? (count == MAXV) : (count == '0);

  // ---- stage p0: counter state (count, tc, dir) ----
  // Counter register: reset > load > enabled step > hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      tc    <= 1'b0;
      dir   <= 1'b1;
    end else if (load) begin
      count <= clamp_load(load_val);
      tc    <= 1'b0;
      dir   <= up;
    end else if (en) begin
      count <= step_count(count, up, at_limit);
      tc    <= at_limit;
      dir   <= up;
    end else begin
      tc    <= 1'b0;
    end
  end

  // Scan prescaler; each terminal count advances the selected digit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc <= '0;
      digit <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      digit <= (digit == DIGIT_LAST) ? '0 : (digit + IW'(1));
    end else begin
      presc <= presc + PW'(1);
    end
  end

  logic [15:0]        count_ext;
  logic [1:0]         dsel;
  logic [3:0]         nibble_p0;
  logic [6:0]         seg_p0;
  logic [NDIGITS-1:0] an_p0;
  logic               dp_p0;

  assign count_ext = 16'(count);
  assign dsel      = 2'(digit);

  // Pick the hex nibble of the count belonging to the selected digit.
  always_comb begin
    nibble_p0 = count_ext[3:0];
    case (dsel)
      2'd1:    nibble_p0 = count_ext[7:4];
      2'd2:    nibble_p0 = count_ext[11:8];
      2'd3:    nibble_p0 = count_ext[15:12];
      default: nibble_p0 = count_ext[3:0];
    endcase
  end

  hex_to_seg7 #(
    .ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_hex_to_seg7 (
    .nibble (nibble_p0),
    .seg    (seg_p0)
  );

  assign an_p0 = (SEG_ACTIVE_LOW != 0) ? ~(AN_ONE << digit) : (AN_ONE << digit);
  assign dp_p0 = ((digit == '0) && !dir) ^ (SEG_ACTIVE_LOW != 0);

  // ---- stage p1: registered display outputs ----
  // Display output registers, one cycle behind the digit index and count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg <= SEG_RST;
      an  <= AN_RST;
      dp  <= DP_OFF;
    end else begin
      seg <= seg_p0;
      an  <= an_p0;
      dp  <= dp_p0;
    end
  end

endmodule

// File: tb/tb_updown_counter_seg.sv
// Bench for updown_counter_seg: three configurations driven from shared inputs
// and compared every cycle against an arithmetic reference model.
module tb_updown_counter_seg;

  logic       clk = 1'b0;
  logic       reset, en, up, load;
  logic [7:0] load_val;

  always #5 clk = ~clk;

  logic [3:0] cnt_w, cnt_s;
  logic [7:0] cnt_x;
  logic       tc_w, tc_s, tc_x, dir_w, dir_s, dir_x, dp_w, dp_s, dp_x;
  logic [6:0] seg_w, seg_s, seg_x;
  logic [0:0] an_w, an_s;
  logic [1:0] an_x;

  updown_counter_seg #(.WIDTH(4), .MOD(10), .SATURATE(0), .NDIGITS(1),
                       .SCAN_DIV(1000), .SEG_ACTIVE_LOW(1)) u_w (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val[3:0]), .count(cnt_w), .tc(tc_w), .dir(dir_w),
    .seg(seg_w), .dp(dp_w), .an(an_w));

  updown_counter_seg #(.WIDTH(4), .MOD(10), .SATURATE(1), .NDIGITS(1),
                       .SCAN_DIV(1000), .SEG_ACTIVE_LOW(1)) u_s (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val[3:0]), .count(cnt_s), .tc(tc_s), .dir(dir_s),
    .seg(seg_s), .dp(dp_s), .an(an_s));

  updown_counter_seg #(.WIDTH(8), .MOD(256), .SATURATE(0), .NDIGITS(2),
                       .SCAN_DIV(4), .SEG_ACTIVE_LOW(1)) u_x (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(cnt_x), .tc(tc_x), .dir(dir_x),
    .seg(seg_x), .dp(dp_x), .an(an_x));

  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int mod_t [3] = '{10, 10, 256};
  int sat_t [3] = '{0, 1, 0};
  int nd_t  [3] = '{1, 1, 2};
  int sd_t  [3] = '{1000, 1000, 4};
  int msk_t [3] = '{15, 15, 255};

  int checks = 0;
  int errors = 0;

  // reference state after the latest edge, and the state just before it
  int mcnt [3] = '{0, 0, 0};
  int mtc  [3] = '{0, 0, 0};
  int mdir [3] = '{1, 1, 1};
  int bcnt [3] = '{0, 0, 0};
  int bdir [3] = '{1, 1, 1};
  int nstep = 0;
  int bstep = 0;
  bit last_reset = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic e, input logic u,
                            input logic l, input logic [7:0] lv);
    int v;
    bit lim;
    bstep = nstep;
    last_reset = !r;
    for (int i = 0; i < 3; i++) begin
      bcnt[i] = mcnt[i];
      bdir[i] = mdir[i];
    end
    if (!r) begin
      nstep = 0;
      for (int i = 0; i < 3; i++) begin
        mcnt[i] = 0; mtc[i] = 0; mdir[i] = 1;
      end
    end else begin
      nstep++;
      for (int i = 0; i < 3; i++) begin
        v = int'(lv) & msk_t[i];
        if (l) begin
          mcnt[i] = (v >= mod_t[i]) ? mod_t[i] - 1 : v;
          mtc[i]  = 0;
          mdir[i] = int'(u);
        end else if (e) begin
          lim     = u ? (mcnt[i] == mod_t[i] - 1) : (mcnt[i] == 0);
          mtc[i]  = int'(lim);
          mdir[i] = int'(u);
          if (!(lim && sat_t[i] == 1))
            mcnt[i] = (mcnt[i] + (u ? 1 : mod_t[i] - 1)) % mod_t[i];
        end else begin
          mtc[i] = 0;
        end
      end
    end
  endtask

  task automatic check_inst(input int i, input logic [31:0] c, input logic [31:0] t,
                            input logic [31:0] d, input logic [31:0] s,
                            input logic [31:0] p, input logic [31:0] a);
    int dig, nib, dv;
    logic [6:0] es;
    if (last_reset) begin
      dig = 0; nib = 0; dv = 1;
    end else begin
      dig = (bstep / sd_t[i]) % nd_t[i];
      nib = (bcnt[i] >> (4 * dig)) & 15;
      dv  = bdir[i];
    end
    es = ~FONT[nib];
    chk($sformatf("u%0d count", i), c, mcnt[i]);
    chk($sformatf("u%0d tc", i), t, mtc[i]);
    chk($sformatf("u%0d dir", i), d, mdir[i]);
    chk($sformatf("u%0d seg", i), s, {25'd0, es});
    chk($sformatf("u%0d an", i), a, (~(1 << dig)) & ((1 << nd_t[i]) - 1));
    chk($sformatf("u%0d dp", i), p, (dig == 0 && dv == 0) ? 0 : 1);
  endtask

  task automatic cyc(input logic r, input logic e, input logic u,
                     input logic l, input logic [7:0] lv);
    @(negedge clk);
    reset = r; en = e; up = u; load = l; load_val = lv;
    @(posedge clk);
    model_edge(r, e, u, l, lv);
    #1;
    check_inst(0, 32'(cnt_w), 32'(tc_w), 32'(dir_w), 32'(seg_w), 32'(dp_w), 32'(an_w));
    check_inst(1, 32'(cnt_s), 32'(tc_s), 32'(dir_s), 32'(seg_s), 32'(dp_s), 32'(an_s));
    check_inst(2, 32'(cnt_x), 32'(tc_x), 32'(dir_x), 32'(seg_x), 32'(dp_x), 32'(an_x));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;

    // reset defaults
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("rst seg lit", 32'(seg_w), 32'h40);
    chk("rst dp lit", 32'(dp_w), 32'h1);
    chk("rst an lit", 32'(an_w), 32'h0);

    // wrap up through 9 -> 0
    repeat (12) cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    chk("wrapup count lit", 32'(cnt_w), 32'd2);

    // load 0, then count down with wrap to 9
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("wrapdn tc lit", 32'(tc_w), 32'h1);
    chk("wrapdn count lit", 32'(cnt_w), 32'd9);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("wrapdn count7 lit", 32'(cnt_w), 32'd7);
    chk("wrapdn dp lit", 32'(dp_w), 32'h0);

    // clamp and saturate
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h0F);
    chk("clamp lit", 32'(cnt_s), 32'd9);
    repeat (3) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      chk("sat tc lit", 32'(tc_s), 32'h1);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("sat down lit", 32'(cnt_s), 32'd8);

    // load beats enable; reset beats enable
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h05);
    chk("prio load lit", 32'(cnt_w), 32'd5);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    chk("prio rst lit", 32'(cnt_w), 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    chk("resume lit", 32'(cnt_w), 32'd1);

    // scan two digits of 0xA3
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'hA3);
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("scan d0 seg lit", 32'(seg_x), 32'h30);
    chk("scan d0 an lit", 32'(an_x), 32'h2);
    repeat (4) cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("scan d1 seg lit", 32'(seg_x), 32'h08);
    chk("scan d1 an lit", 32'(an_x), 32'h1);
    repeat (6) cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 39) != 0), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 7) == 0), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
